// File: rtl/k12a_spi_pkg.sv
// Shared types and constants for the k12a SPI target endpoint.
package k12a_spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_target_state_t;

  localparam int SPI_BITS = 8;
  localparam logic [SPI_BITS-1:0] SPI_UNDERRUN_FILL = 8'hFF;

  localparam int STAT_RX_FULL  = 7;
  localparam int STAT_TX_EMPTY = 6;
  localparam int STAT_OVERRUN  = 5;
  localparam int STAT_UNDERRUN = 4;

  function automatic logic [SPI_BITS-1:0] pack_status(
    input logic rx_full,
    input logic tx_empty,
    input logic overrun,
    input logic underrun
  );
    logic [SPI_BITS-1:0] s;
    s = '0;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_OVERRUN]  = overrun;
    s[STAT_UNDERRUN] = underrun;
    return s;
  endfunction

endpackage

// File: rtl/k12a_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, followed by a one-flop
// history that turns level changes into single-cycle rise/fall pulses.
module k12a_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   level_s;

  assign level_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= level_s;
    end
  end

  assign rise_o = level_s & ~hist_q;
  assign fall_o = ~level_s & hist_q;

endmodule

// File: rtl/k12a_spi_target.sv
// SPI target endpoint: oversampled pins, MSB-first, one-byte RX/TX buffers.
// Build option K12A_SPI_TARGET_MODE_SEL_EN adds spi_cpol/spi_cpha mode inputs.
module k12a_spi_target
  import k12a_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_ss_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
`ifdef K12A_SPI_TARGET_MODE_SEL_EN
  input  logic       spi_cpol,
  input  logic       spi_cpha,
`endif
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       data_load,
  input  logic       data_store,
  input  logic       status_load,
  inout  wire  [7:0] data_bus,
  output logic       rx_ready
);

  localparam int CNT_W = $clog2(SPI_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_target_state_t   state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
  logic [SPI_BITS-1:0] tx_buf_q, tx_buf_d;
  logic rx_full_q, rx_full_d;
  logic tx_empty_q, tx_empty_d;
  logic overrun_q, overrun_d;
  logic underrun_q, underrun_d;

  logic mode_cpol, mode_cpha;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic reload, rx_complete, overrun_set, underrun_set, status_rd;
  logic [SPI_BITS-1:0] rx_byte, status_byte;

  k12a_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clock  (clock),
    .reset  (reset),
    .async_i(spi_sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // Select idles high, so it resets high to avoid a phantom select edge.
  k12a_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clock  (clock),
    .reset  (reset),
    .async_i(spi_ss_n),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // MOSI needs no edge detect; same depth keeps it aligned with sck events.
  always_ff @(posedge clock) begin
    if (reset) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef K12A_SPI_TARGET_MODE_SEL_EN
  logic cpol_q, cpol_d, cpha_q, cpha_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else begin
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
    end
  end

  always_comb begin
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    if (state_q == IDLE && ss_fall) begin
      cpol_d = spi_cpol;
      cpha_d = spi_cpha;
    end
  end

  assign mode_cpol = cpol_q;
  assign mode_cpha = cpha_q;
`else
  assign mode_cpol = 1'b0;
  assign mode_cpha = 1'b0;
`endif

  assign lead_edge   = mode_cpol ? sck_fall : sck_rise;
  assign trail_edge  = mode_cpol ? sck_rise : sck_fall;
  assign sample_edge = mode_cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode_cpha ? lead_edge : trail_edge;

  assign rx_byte     = {rx_shift_q[SPI_BITS-2:0], mosi_s};
  assign status_byte = pack_status(rx_full_q, tx_empty_q, overrun_q, underrun_q);
  assign status_rd   = status_load & ~data_load;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    rx_data_d    = rx_data_q;
    tx_buf_d     = tx_buf_q;
    rx_full_d    = rx_full_q;
    tx_empty_d   = tx_empty_q;
    reload       = 1'b0;
    rx_complete  = 1'b0;
    overrun_set  = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          reload    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sample_edge) begin
          rx_shift_d = rx_byte;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            reload    = 1'b1;
            // A read in the completion cycle frees the buffer, so it is no overrun.
            if (!rx_full_q || data_load) begin
              rx_data_d   = rx_byte;
              rx_complete = 1'b1;
            end else begin
              overrun_set = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge && bit_cnt_q != '0) begin
          // No shift before the first sample of a byte: bit 7 was just loaded.
          tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      if (!tx_empty_q) begin
        tx_shift_d = tx_buf_q;
      end else begin
        tx_shift_d   = SPI_UNDERRUN_FILL;
        underrun_set = 1'b1;
      end
      tx_empty_d = 1'b1;
    end
    if (data_store) begin
      tx_buf_d   = data_bus;
      tx_empty_d = 1'b0;
    end

    if (data_load) begin
      rx_full_d = 1'b0;
    end
    if (rx_complete) begin
      rx_full_d = 1'b1;
    end

    overrun_d  = overrun_set  | (overrun_q  & ~status_rd);
    underrun_d = underrun_set | (underrun_q & ~status_rd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_buf_q   <= '0;
      rx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_buf_q   <= tx_buf_d;
      rx_full_q  <= rx_full_d;
      tx_empty_q <= tx_empty_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign spi_miso_oe = (state_q == ACTIVE);
  assign spi_miso    = (state_q == ACTIVE) & tx_shift_q[SPI_BITS-1];
  assign rx_ready    = rx_full_q;

  assign data_bus = data_load   ? rx_data_q :
                    status_load ? status_byte : 8'hzz;

endmodule

// File: tb/tb_k12a_spi_target.sv
// Directed bench for k12a_spi_target: host byte transfers at clock/8 plus CPU accesses.
module tb_k12a_spi_target;

  localparam int SYNC_STAGES = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic spi_ss_n = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_mosi = 1'b0;
  logic data_load = 1'b0;
  logic data_store = 1'b0;
  logic status_load = 1'b0;
`ifdef K12A_SPI_TARGET_MODE_SEL_EN
  logic spi_cpol = 1'b0;
  logic spi_cpha = 1'b0;
`endif
  logic tb_bus_en = 1'b0;
  logic [7:0] tb_bus_val = 8'h00;

  wire spi_miso;
  wire spi_miso_oe;
  wire rx_ready;
  wire [7:0] data_bus;

  int vec_cnt = 0;
  int err_cnt = 0;

  assign data_bus = tb_bus_en ? tb_bus_val : 8'hzz;

  always #5 clock = ~clock;

  k12a_spi_target #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clock      (clock),
    .reset      (reset),
    .spi_ss_n   (spi_ss_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
`ifdef K12A_SPI_TARGET_MODE_SEL_EN
    .spi_cpol   (spi_cpol),
    .spi_cpha   (spi_cpha),
`endif
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .data_load  (data_load),
    .data_store (data_store),
    .status_load(status_load),
    .data_bus   (data_bus),
    .rx_ready   (rx_ready)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_store(input logic [7:0] v);
    tb_bus_val = v;
    tb_bus_en  = 1'b1;
    data_store = 1'b1;
    step();
    data_store = 1'b0;
    tb_bus_en  = 1'b0;
  endtask

  task automatic cpu_read_data(output logic [7:0] v);
    data_load = 1'b1;
    #1;
    v = data_bus;
    @(posedge clock);
    #1;
    data_load = 1'b0;
  endtask

  task automatic cpu_read_status(output logic [7:0] v);
    status_load = 1'b1;
    #1;
    v = data_bus;
    @(posedge clock);
    #1;
    status_load = 1'b0;
  endtask

  task automatic host_select();
    spi_ss_n = 1'b0;
    repeat (6) step();
  endtask

  task automatic host_deselect();
    spi_ss_n = 1'b1;
    repeat (6) step();
  endtask

  // Mode 0 host at clock/8; optional CPU store mid-byte and CPU data read
  // placed in the exact cycle the target acts on the 8th rising sck edge.
  task automatic host_byte(input logic [7:0] tx, input int nbits,
                           input bit mid_store, input logic [7:0] store_val,
                           input bit load_at_end,
                           output logic [7:0] rx, output logic [7:0] end_bus);
    rx = 8'h00;
    end_bus = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      if (mid_store && i == 3) begin
        cpu_store(store_val);
        repeat (3) step();
      end else begin
        repeat (4) step();
      end
      spi_sck = 1'b1;
      rx[i] = spi_miso;
      if (load_at_end && i == 0) begin
        repeat (2) step();
        data_load = 1'b1;
        #1;
        end_bus = data_bus;
        @(posedge clock);
        #1;
        data_load = 1'b0;
        step();
      end else begin
        repeat (4) step();
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    vec_cnt++;
    if (spi_miso_oe !== 1'b0) begin
      err_cnt++; $display("FAIL reset_oe: got %b expected 0", spi_miso_oe);
    end
    vec_cnt++;
    if (spi_miso !== 1'b0) begin
      err_cnt++; $display("FAIL reset_miso: got %b expected 0", spi_miso);
    end
    vec_cnt++;
    if (rx_ready !== 1'b0) begin
      err_cnt++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'h40) begin
      err_cnt++; $display("FAIL reset_status: got %02h expected 40", v);
    end
    cpu_read_data(v);
    vec_cnt++;
    if (v !== 8'h00) begin
      err_cnt++; $display("FAIL reset_rx_data: got %02h expected 00", v);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_xfer();
    logic [7:0] rx, eb, v;
    cpu_store(8'hA5);
    host_select();
    // Second store mid-byte feeds the end-of-byte reload, so no underrun.
    host_byte(8'h3C, 8, 1'b1, 8'h5A, 1'b0, rx, eb);
    vec_cnt++;
    if (rx !== 8'hA5) begin
      err_cnt++; $display("FAIL basic_miso_byte: got %02h expected a5", rx);
    end
    vec_cnt++;
    if (rx_ready !== 1'b1) begin
      err_cnt++; $display("FAIL basic_rx_ready: got %b expected 1", rx_ready);
    end
    host_deselect();
    cpu_read_data(v);
    vec_cnt++;
    if (v !== 8'h3C) begin
      err_cnt++; $display("FAIL basic_rx_data: got %02h expected 3c", v);
    end
    vec_cnt++;
    if (rx_ready !== 1'b0) begin
      err_cnt++; $display("FAIL basic_rx_ready_clr: got %b expected 0", rx_ready);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'h40) begin
      err_cnt++; $display("FAIL basic_status: got %02h expected 40", v);
    end
    $display("test_basic_xfer done: host got %02h", rx);
  endtask

  task automatic test_overrun();
    logic [7:0] rx1, rx2, eb, v;
    host_select();
    host_byte(8'h11, 8, 1'b0, 8'h00, 1'b0, rx1, eb);
    host_byte(8'h22, 8, 1'b0, 8'h00, 1'b0, rx2, eb);
    host_deselect();
    vec_cnt++;
    if (rx1 !== 8'hFF || rx2 !== 8'hFF) begin
      err_cnt++; $display("FAIL overrun_miso_fill: got %02h %02h expected ff ff", rx1, rx2);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'hF0) begin
      err_cnt++; $display("FAIL overrun_status1: got %02h expected f0", v);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'hC0) begin
      err_cnt++; $display("FAIL overrun_status2: got %02h expected c0", v);
    end
    cpu_read_data(v);
    vec_cnt++;
    if (v !== 8'h11) begin
      err_cnt++; $display("FAIL overrun_rx_data: got %02h expected 11", v);
    end
    $display("test_overrun done");
  endtask

  task automatic test_underrun();
    logic [7:0] rx, eb, v;
    host_select();
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'h50) begin
      err_cnt++; $display("FAIL underrun_status_set: got %02h expected 50", v);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'h40) begin
      err_cnt++; $display("FAIL underrun_status_clr: got %02h expected 40", v);
    end
    host_byte(8'hC3, 8, 1'b0, 8'h00, 1'b0, rx, eb);
    host_deselect();
    vec_cnt++;
    if (rx !== 8'hFF) begin
      err_cnt++; $display("FAIL underrun_miso: got %02h expected ff", rx);
    end
    cpu_read_data(v);
    vec_cnt++;
    if (v !== 8'hC3) begin
      err_cnt++; $display("FAIL underrun_rx_data: got %02h expected c3", v);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'h50) begin
      err_cnt++; $display("FAIL underrun_status_reload: got %02h expected 50", v);
    end
    $display("test_underrun done");
  endtask

  task automatic test_partial_deselect();
    logic [7:0] rx, eb, v;
    int waited;
    cpu_store(8'h33);
    host_select();
    host_byte(8'hF0, 5, 1'b0, 8'h00, 1'b0, rx, eb);
    vec_cnt++;
    if (rx !== 8'h30) begin
      err_cnt++; $display("FAIL partial_miso_bits: got %02h expected 30", rx);
    end
    spi_ss_n = 1'b1;
    waited = 0;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      step();
      waited = k;
      if (spi_miso_oe === 1'b0) break;
    end
    vec_cnt++;
    if (spi_miso_oe !== 1'b0) begin
      err_cnt++; $display("FAIL partial_oe_drop: got oe=%b after %0d cycles expected 0", spi_miso_oe, waited);
    end
    repeat (4) step();
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'h40) begin
      err_cnt++; $display("FAIL partial_status: got %02h expected 40", v);
    end
    cpu_store(8'h44);
    host_select();
    host_byte(8'h81, 8, 1'b1, 8'h55, 1'b0, rx, eb);
    host_deselect();
    vec_cnt++;
    if (rx !== 8'h44) begin
      err_cnt++; $display("FAIL partial_next_miso: got %02h expected 44", rx);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'hC0) begin
      err_cnt++; $display("FAIL partial_next_status: got %02h expected c0", v);
    end
    cpu_read_data(v);
    vec_cnt++;
    if (v !== 8'h81) begin
      err_cnt++; $display("FAIL partial_next_rx_data: got %02h expected 81", v);
    end
    $display("test_partial_deselect done: oe low after %0d cycles", waited);
  endtask

  task automatic test_load_at_completion();
    logic [7:0] rx, eb, v;
    cpu_store(8'h66);
    host_select();
    host_byte(8'h9E, 8, 1'b1, 8'h77, 1'b0, rx, eb);
    vec_cnt++;
    if (rx !== 8'h66) begin
      err_cnt++; $display("FAIL collide_miso1: got %02h expected 66", rx);
    end
    host_byte(8'h27, 8, 1'b1, 8'h88, 1'b1, rx, eb);
    host_deselect();
    vec_cnt++;
    if (rx !== 8'h77) begin
      err_cnt++; $display("FAIL collide_miso2: got %02h expected 77", rx);
    end
    vec_cnt++;
    if (eb !== 8'h9E) begin
      err_cnt++; $display("FAIL collide_old_byte: got %02h expected 9e", eb);
    end
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'hC0) begin
      err_cnt++; $display("FAIL collide_status: got %02h expected c0", v);
    end
    cpu_read_data(v);
    vec_cnt++;
    if (v !== 8'h27) begin
      err_cnt++; $display("FAIL collide_new_byte: got %02h expected 27", v);
    end
    $display("test_load_at_completion done");
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] rx, eb, v;
    host_select();
    host_byte(8'hAA, 3, 1'b0, 8'h00, 1'b0, rx, eb);
    reset = 1'b1;
    repeat (2) step();
    vec_cnt++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
      err_cnt++; $display("FAIL midreset_pins: got oe=%b miso=%b expected 0 0", spi_miso_oe, spi_miso);
    end
    vec_cnt++;
    if (rx_ready !== 1'b0) begin
      err_cnt++; $display("FAIL midreset_rx_ready: got %b expected 0", rx_ready);
    end
    reset = 1'b0;
    cpu_read_status(v);
    vec_cnt++;
    if (v !== 8'h40) begin
      err_cnt++; $display("FAIL midreset_status: got %02h expected 40", v);
    end
    host_deselect();
    cpu_store(8'h96);
    host_select();
    host_byte(8'h5A, 8, 1'b1, 8'h11, 1'b0, rx, eb);
    host_deselect();
    vec_cnt++;
    if (rx !== 8'h96) begin
      err_cnt++; $display("FAIL midreset_miso: got %02h expected 96", rx);
    end
    cpu_read_data(v);
    vec_cnt++;
    if (v !== 8'h5A) begin
      err_cnt++; $display("FAIL midreset_rx_data: got %02h expected 5a", v);
    end
    $display("test_reset_mid_byte done");
  endtask

  initial begin
    test_reset();
    test_basic_xfer();
    test_overrun();
    test_underrun();
    test_partial_deselect();
    test_load_at_completion();
    test_reset_mid_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
